// File: rtl/moving_avg_filter_if.sv
// Sample stream into the boxcar filter and its filtered result stream.
// The master side produces samples and consumes results; the filter is the slave side.
interface moving_avg_filter_if #(
   parameter int DATA_W = 16
);
   logic signed [DATA_W-1:0] DIN;
   logic                     DIN_VALID;
   logic signed [DATA_W-1:0] DOUT;
   logic                     DOUT_VALID;
   logic                     PRIMED;

   modport master (
      output DIN, DIN_VALID,
      input  DOUT, DOUT_VALID, PRIMED
   );

   modport slave (
      input  DIN, DIN_VALID,
      output DOUT, DOUT_VALID, PRIMED
   );
endinterface

// File: rtl/moving_avg_filter.sv
// Boxcar low-pass filter: outputs the floor mean of the last 2^LOG2_TAPS signed samples.
// A running accumulator is updated incrementally with the newest sample minus the one it evicts.
module moving_avg_filter #(
   parameter int DATA_W    = 16,
   parameter int LOG2_TAPS = 3
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET,
   input  logic                 CLEAR,
   moving_avg_filter_if.slave   bus
);
   localparam int N  = 1 << LOG2_TAPS;
   localparam int AW = DATA_W + LOG2_TAPS;
   localparam logic [LOG2_TAPS:0] FILL_LAST = (LOG2_TAPS+1)'(N - 1);
   localparam logic [LOG2_TAPS:0] FILL_FULL = (LOG2_TAPS+1)'(N);

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t                   state_reg, state_next;
   logic signed [DATA_W-1:0] history_reg [N];
   logic [LOG2_TAPS-1:0]     wp_reg;
   logic signed [AW-1:0]     acc_reg, acc_next;
   logic [LOG2_TAPS:0]       fill_reg, fill_next;
   logic signed [DATA_W-1:0] dout_reg;
   logic                     dout_valid_reg;
   logic                     primed_reg, primed_next;

   logic flush;
   logic accept;
   logic signed [AW-1:0] din_ext;
   logic signed [AW-1:0] oldest_ext;

   assign flush  = RESET | CLEAR;
   assign accept = bus.DIN_VALID & ~flush;

   assign din_ext    = {{LOG2_TAPS{bus.DIN[DATA_W-1]}}, bus.DIN};
   assign oldest_ext = {{LOG2_TAPS{history_reg[wp_reg][DATA_W-1]}}, history_reg[wp_reg]};
   assign acc_next   = acc_reg + din_ext - oldest_ext;

   // One register per window slot so a flush can zero the whole history in one edge.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_history
         always_ff @(posedge CLOCK_50) begin
            if (flush) begin
               history_reg[gi] <= '0;
            end else if (accept && (wp_reg == LOG2_TAPS'(gi))) begin
               history_reg[gi] <= bus.DIN;
            end
         end
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      fill_next   = fill_reg;
      primed_next = primed_reg;
      case (state_reg)
         S_FILL: begin
            if (bus.DIN_VALID) begin
               fill_next = fill_reg + 1'b1;
               if (fill_reg == FILL_LAST) begin
                  state_next  = S_RUN;
                  primed_next = 1'b1;
               end
            end
         end
         S_RUN: begin
            fill_next   = FILL_FULL;
            primed_next = 1'b1;
         end
         default: begin
            state_next = S_FILL;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (flush) begin
         state_reg  <= S_FILL;
         fill_reg   <= '0;
         primed_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         fill_reg   <= fill_next;
         primed_reg <= primed_next;
      end
   end

   // Bits [LOG2_TAPS +: DATA_W] are the arithmetic right shift, which floors toward -inf.
   always_ff @(posedge CLOCK_50) begin
      if (flush) begin
         wp_reg         <= '0;
         acc_reg        <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
      end else if (bus.DIN_VALID) begin
         wp_reg         <= wp_reg + 1'b1;
         acc_reg        <= acc_next;
         dout_reg       <= acc_next[LOG2_TAPS +: DATA_W];
         dout_valid_reg <= 1'b1;
      end else begin
         dout_valid_reg <= 1'b0;
      end
   end

   assign bus.DOUT       = dout_reg;
   assign bus.DOUT_VALID = dout_valid_reg;
   assign bus.PRIMED     = primed_reg;
endmodule
